ysyx_25040111_mem_arbiter: RTL and testbench
============================================

Name: ysyx_25040111_mem_arbiter

Overview:
- Two-master to one-slave AXI4 single-beat arbiter.
- Shares the single memory/MMIO bus between the IFU (master 0, read-only) and the LSU (master 1, read and write).
- Sits between both units and the SoC io_master port (or the local SRAM model in non-SoC builds).
- Grants exactly one outstanding transaction at a time, with round-robin fairness between masters.

Parameters:
- ADDR_W, 32, address width of every AR/AW channel
- DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8

Ports:
- clk  in  1  clock; every register updates on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_arvalid, m0_rready  in  1  IFU read-address valid / read-data ready
- m0_araddr  in  ADDR_W  IFU read address
- m0_arsize  in  3  IFU transfer size
- m0_arready, m0_rvalid  out  1  IFU handshake returns
- m0_rdata  out  DATA_W  read data to IFU
- m0_rresp  out  2  read response to IFU
- m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready  in  1  LSU channel valids/readies
- m1_araddr, m1_awaddr  in  ADDR_W  LSU read and write addresses
- m1_arsize, m1_awsize  in  3  LSU transfer sizes
- m1_wdata  in  DATA_W  LSU write data
- m1_wstrb  in  DATA_W/8  LSU byte strobes
- m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid  out  1  LSU handshake returns
- m1_rdata  out  DATA_W  read data to LSU
- m1_rresp, m1_bresp  out  2  LSU responses
- s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready  out  1  slave-side valids/readies
- s_araddr, s_awaddr  out  ADDR_W  slave addresses
- s_arsize, s_awsize  out  3  slave sizes
- s_arid, s_awid  out  4  transaction IDs
- s_arlen, s_awlen  out  8  burst length, constant 0
- s_arburst, s_awburst  out  2  burst type, constant 2'b01
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave strobes
- s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid  in  1  slave handshake returns
- s_rdata  in  DATA_W  slave read data
- s_rresp, s_bresp  in  2  slave responses

Behaviour:
- State and registers
  - States: IDLE, AR, R, WR, B.
  - Registers: state, owner (1 bit), last_owner (1 bit), aw_done, w_done.
- Reset (async, rst_n=0)
  - state=IDLE, owner=0, last_owner=1, aw_done=w_done=0.
  - All valid/ready outputs are 0 immediately, since they decode from state.
  - Reset mid-transaction abandons it; the slave shares rst_n.
- IDLE
  - Every ready/valid output is 0. No combinational path from master valids to readies.
  - Requests: req0=m0_arvalid; req1=m1_arvalid|m1_awvalid.
  - Only one requesting: it wins.
  - Both requesting: the master != last_owner wins. After reset, IFU wins the first tie.
  - On the edge: owner<=winner.
  - Next state: AR if the winner is m0 or m1_arvalid=1; else WR. LSU read beats LSU write when both are asserted.
- Grant latency: request sampled at edge N, slave valid visible in cycle N+1.
- AR
  - s_arvalid / s_araddr / s_arsize come from the owner; s_arid={3'b0,owner}.
  - Owner's arready=s_arready; the other master's arready=0.
  - Handshake (s_arvalid&s_arready) -> R.
  - Grant is held even if the owner drops arvalid.
- R
  - s_rready = owner's rready; owner's rvalid=s_rvalid.
  - rdata/rresp are wired to both masters; only the owner sees rvalid.
  - Handshake -> IDLE, last_owner<=owner.
  - s_rlast is ignored (len=0).
- WR (owner is always m1)
  - s_awvalid=m1_awvalid&~aw_done; s_wvalid=m1_wvalid&~w_done.
  - m1_awready/m1_wready are gated the same way.
  - s_awid=4'd1; s_wlast=s_wvalid.
  - aw_done/w_done set on their respective handshakes, so AW and W may complete in either order or in the same cycle.
  - Exit to B on the cycle both are done, counting a same-cycle handshake. Clear both flags on exit.
- B
  - s_bready=m1_bready; m1_bvalid=s_bvalid; m1_bresp=s_bresp.
  - Handshake -> IDLE, last_owner<=1.
- Constants: s_arlen=s_awlen=0; s_arburst=s_awburst=2'b01.
- Addresses/data: always driven from the owner, and held stable while its valid is asserted.
- Errors: responses are forwarded unmodified. The arbiter never generates or masks an error.

Test Plan:
- IFU read alone: m0_arvalid at cycle 0, addr 0x3000_0000 -> s_arvalid high cycle 1 with s_arid=0; slave returns rdata 0xDEADBEEF -> m0_rvalid with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Simultaneous m0_arvalid and m1_arvalid right after reset -> IFU granted first; LSU granted immediately after IFU's R handshake; a third tie is then won by IFU.
- LSU write, W handshake one cycle before AW (slave wready early) -> single AW and single W on the slave; state reaches B only after both; m1_bresp=2'b00 is forwarded.
- LSU write with AW and W accepted the same cycle, slave bvalid held 3 cycles with m1_bready=0 -> bvalid stays visible, no new grant until the B handshake.
- LSU with arvalid and awvalid both high -> read is served first, then the write; s_awid=1.
- rst_n asserted in state R -> all s_* valids and readies drop to 0 immediately; after release, a fresh IFU read completes normally.

Source files
------------

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Two-master / one-slave AXI4 single-beat arbiter.
// Master 0 is the IFU (read only), master 1 is the LSU (read and write).
// Exactly one transaction is outstanding at a time; ties are broken
// round-robin against the master that completed the previous transaction.
module ysyx_25040111_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU (master 0)
  input  logic                m0_arvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arsize,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  // LSU (master 1)
  input  logic                m1_arvalid,
  input  logic                m1_rready,
  input  logic                m1_awvalid,
  input  logic                m1_wvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_arsize,
  input  logic [2:0]          m1_awsize,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic                m1_awready,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic [1:0]          m1_bresp,
  // Slave side
  output logic                s_arvalid,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic                s_wvalid,
  output logic                s_wlast,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_arsize,
  output logic [2:0]          s_awsize,
  output logic [3:0]          s_arid,
  output logic [3:0]          s_awid,
  output logic [7:0]          s_arlen,
  output logic [7:0]          s_awlen,
  output logic [1:0]          s_arburst,
  output logic [1:0]          s_awburst,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic                s_rlast,
  input  logic                s_awready,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic [1:0]          s_bresp
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic   req0, req1, winner;
  logic   ar_v, aw_v, w_v, aw_hs, w_hs;

  // Single-beat bursts: rlast carries no information here.
  logic   unused_rlast;
  assign unused_rlast = s_rlast;

  assign req0   = m0_arvalid;
  assign req1   = m1_arvalid | m1_awvalid;
  // On a tie the master that did not finish last wins; otherwise the lone requester.
  assign winner = (req0 && req1) ? ~last_owner_q : req1;

  // Address/data paths always follow the current owner; read/write responses are broadcast.
  assign s_araddr  = owner_q ? m1_araddr : m0_araddr;
  assign s_arsize  = owner_q ? m1_arsize : m0_arsize;
  assign s_arid    = {3'b000, owner_q};
  assign s_arlen   = 8'd0;
  assign s_arburst = 2'b01;
  assign s_awaddr  = m1_awaddr;
  assign s_awsize  = m1_awsize;
  assign s_awid    = 4'd1;
  assign s_awlen   = 8'd0;
  assign s_awburst = 2'b01;
  assign s_wdata   = m1_wdata;
  assign s_wstrb   = m1_wstrb;
  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_bresp  = s_bresp;

  // Write-side gating: each of AW and W is presented exactly once per grant.
  assign ar_v  = owner_q ? m1_arvalid : m0_arvalid;
  assign aw_v  = m1_awvalid & ~aw_done_q;
  assign w_v   = m1_wvalid & ~w_done_q;
  assign aw_hs = aw_v & s_awready;
  assign w_hs  = w_v & s_wready;

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  // Next-state logic and handshake decode; all valids/readies derive from state.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    s_awvalid    = 1'b0;
    s_wvalid     = 1'b0;
    s_wlast      = 1'b0;
    s_bready     = 1'b0;
    m0_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_arready   = 1'b0;
    m1_rvalid    = 1'b0;
    m1_awready   = 1'b0;
    m1_wready    = 1'b0;
    m1_bvalid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          // An LSU read takes precedence over an LSU write.
          state_d = (!winner || m1_arvalid) ? AR : WR;
        end
      end
      AR: begin
        s_arvalid  = ar_v;
        m0_arready = ~owner_q & s_arready;
        m1_arready = owner_q & s_arready;
        if (ar_v && s_arready) state_d = R;
      end
      R: begin
        s_rready  = owner_q ? m1_rready : m0_rready;
        m0_rvalid = ~owner_q & s_rvalid;
        m1_rvalid = owner_q & s_rvalid;
        if (s_rready && s_rvalid) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      WR: begin
        s_awvalid  = aw_v;
        s_wvalid   = w_v;
        s_wlast    = w_v;
        m1_awready = s_awready & ~aw_done_q;
        m1_wready  = s_wready & ~w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      B: begin
        s_bready  = m1_bready;
        m1_bvalid = s_bvalid;
        if (m1_bready && s_bvalid) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Directed bench for the two-master AXI arbiter: the bench plays both masters
// and the slave; read/write responses are scoreboarded when driven and
// checked when they appear at the master ports.
module tb_ysyx_25040111_mem_arbiter;

  logic        clk, rst_n;
  logic        m0_arvalid, m0_rready;
  logic [31:0] m0_araddr;
  logic [2:0]  m0_arsize;
  logic        m0_arready, m0_rvalid;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
  logic [31:0] m1_araddr, m1_awaddr, m1_wdata;
  logic [2:0]  m1_arsize, m1_awsize;
  logic [3:0]  m1_wstrb;
  logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp, m1_bresp;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [2:0]  s_arsize, s_awsize;
  logic [3:0]  s_arid, s_awid, s_wstrb;
  logic [7:0]  s_arlen, s_awlen;
  logic [1:0]  s_arburst, s_awburst;
  logic        s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  ysyx_25040111_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_rready(m0_rready), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
    .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_rready(m1_rready), .m1_awvalid(m1_awvalid), .m1_wvalid(m1_wvalid),
    .m1_bready(m1_bready), .m1_araddr(m1_araddr), .m1_awaddr(m1_awaddr), .m1_arsize(m1_arsize),
    .m1_awsize(m1_awsize), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_awready(m1_awready), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_rready(s_rready), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
    .s_wlast(s_wlast), .s_bready(s_bready), .s_araddr(s_araddr), .s_awaddr(s_awaddr),
    .s_arsize(s_arsize), .s_awsize(s_awsize), .s_arid(s_arid), .s_awid(s_awid),
    .s_arlen(s_arlen), .s_awlen(s_awlen), .s_arburst(s_arburst), .s_awburst(s_awburst),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_awready(s_awready),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_b;
    bit          id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  int   aw_hs_cnt = 0;
  int   w_hs_cnt = 0;
  int   aw_base, w_base;

  // Count slave-side AW/W handshakes to prove each is issued exactly once.
  always @(posedge clk) begin
    if (s_awvalid && s_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (s_wvalid && s_wready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_b, input bit id, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.is_b = is_b;
    e.id   = id;
    e.data = data;
    e.resp = resp;
    sb.push_back(e);
  endtask

  // Called in the cycle the DUT should be presenting a response to a master.
  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_b) begin
        chk("b_valid", m1_bvalid, 1);
        chk("b_resp", m1_bresp, e.resp);
        $display("txn: B  m1 bresp=%0h", m1_bresp);
      end else begin
        chk("r_valid_route", {m1_rvalid, m0_rvalid}, e.id ? 2'b10 : 2'b01);
        chk("r_data", e.id ? m1_rdata : m0_rdata, e.data);
        chk("r_resp", e.id ? m1_rresp : m0_rresp, e.resp);
        $display("txn: R  m%0d rdata=%08h rresp=%0h", e.id, e.id ? m1_rdata : m0_rdata,
                 e.id ? m1_rresp : m0_rresp);
      end
    end
  endtask

  // Called in the first cycle of AR; completes the address handshake.
  task automatic ar_phase(input bit own, input logic [31:0] addr, input logic [2:0] size);
    chk("ar_valid", s_arvalid, 1);
    chk("ar_id", s_arid, {3'b000, own});
    chk("ar_addr", s_araddr, addr);
    chk("ar_size", s_arsize, size);
    s_arready = 1'b1;
    #1;
    chk("ar_ready_route", {m1_arready, m0_arready}, own ? 2'b10 : 2'b01);
    tick();
    s_arready = 1'b0;
    if (own) m1_arvalid = 1'b0;
    else     m0_arvalid = 1'b0;
  endtask

  // Called in the first cycle of R; returns data and leaves the DUT in IDLE.
  task automatic r_phase(input bit own, input logic [31:0] data, input logic [1:0] resp);
    push_exp(1'b0, own, data, resp);
    s_rdata  = data;
    s_rresp  = resp;
    s_rvalid = 1'b1;
    #1;
    chk("r_s_rready", s_rready, 1);
    pop_check();
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("r_back_idle", {s_arvalid, s_rready, m0_rvalid, m1_rvalid}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_arvalid = 0; m0_rready = 1; m0_araddr = 0; m0_arsize = 3'd2;
    m1_arvalid = 0; m1_rready = 1; m1_awvalid = 0; m1_wvalid = 0; m1_bready = 1;
    m1_araddr = 0; m1_awaddr = 0; m1_arsize = 3'd2; m1_awsize = 3'd2; m1_wdata = 0; m1_wstrb = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 1; s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_rdata = 0; s_rresp = 0; s_bresp = 0;

    // Reset with both masters already requesting: nothing may be granted.
    m0_arvalid = 1; m0_araddr = 32'h3000_0000;
    m1_arvalid = 1; m1_araddr = 32'h8000_0010;
    tick(); tick();
    chk("rst_s_handshakes", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready}, 0);
    chk("rst_m_handshakes", {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
    chk("const_len", {s_arlen, s_awlen}, 16'h0000);
    chk("const_burst", {s_arburst, s_awburst}, 4'b0101);
    rst_n = 1'b1;
    #1;
    chk("idle_no_comb_path", {m0_arready, m1_arready, s_arvalid}, 0);

    // Tie right after reset: IFU first, then LSU, then IFU again.
    tick();
    ar_phase(0, 32'h3000_0000, 3'd2);
    r_phase(0, 32'h1111_0000, 2'b00);
    m0_arvalid = 1; m0_araddr = 32'h3000_0004;
    tick();
    ar_phase(1, 32'h8000_0010, 3'd2);
    r_phase(1, 32'h2222_0000, 2'b00);
    m1_arvalid = 1; m1_araddr = 32'h8000_0020;
    tick();
    ar_phase(0, 32'h3000_0004, 3'd2);
    r_phase(0, 32'h3333_0000, 2'b00);
    tick();
    ar_phase(1, 32'h8000_0020, 3'd2);
    r_phase(1, 32'h4444_0000, 2'b10);

    // IFU read alone.
    m0_arvalid = 1; m0_araddr = 32'h3000_0000;
    #1;
    chk("ifu_idle_wait", s_arvalid, 0);
    tick();
    ar_phase(0, 32'h3000_0000, 3'd2);
    r_phase(0, 32'hDEAD_BEEF, 2'b00);

    // LSU write, W accepted one cycle before AW.
    aw_base = aw_hs_cnt; w_base = w_hs_cnt;
    m1_awvalid = 1; m1_awaddr = 32'h8000_0100; m1_wvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    #1;
    chk("wr_idle_quiet", {s_awvalid, s_wvalid, m1_awready, m1_wready}, 0);
    tick();
    chk("wr_valids", {s_awvalid, s_wvalid, s_wlast}, 3'b111);
    chk("wr_awid", s_awid, 4'd1);
    chk("wr_awaddr", s_awaddr, 32'h8000_0100);
    chk("wr_wdata", s_wdata, 32'h1234_5678);
    chk("wr_wstrb", s_wstrb, 4'hF);
    s_wready = 1;
    #1;
    chk("wr_early_wready", {m1_awready, m1_wready}, 2'b01);
    tick();
    s_wready = 0;
    #1;
    chk("wr_w_gated", {s_awvalid, s_wvalid, s_bready}, 3'b100);
    s_awready = 1; s_wready = 1;
    #1;
    chk("wr_aw_ready", {m1_awready, m1_wready}, 2'b10);
    tick();
    s_awready = 0; s_wready = 0; m1_awvalid = 0; m1_wvalid = 0;
    chk("wr_single_aw", 64'(aw_hs_cnt - aw_base), 64'd1);
    chk("wr_single_w", 64'(w_hs_cnt - w_base), 64'd1);
    push_exp(1'b1, 1'b1, 32'h0, 2'b00);
    s_bvalid = 1; s_bresp = 2'b00;
    #1;
    chk("b_s_bready", s_bready, 1);
    pop_check();
    tick();
    s_bvalid = 0;
    #1;
    chk("b_back_idle", {s_bready, m1_bvalid, s_awvalid}, 0);

    // LSU write, AW and W together; B held while LSU stalls, IFU must wait.
    m1_awvalid = 1; m1_awaddr = 32'h8000_0200; m1_wvalid = 1; m1_wdata = 32'h0000_ABCD; m1_wstrb = 4'b0011;
    m1_bready = 0;
    tick();
    s_awready = 1; s_wready = 1;
    #1;
    chk("wr2_both_ready", {m1_awready, m1_wready}, 2'b11);
    tick();
    s_awready = 0; s_wready = 0; m1_awvalid = 0; m1_wvalid = 0;
    m0_arvalid = 1; m0_araddr = 32'h3000_0200;
    s_bvalid = 1; s_bresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bhold_bvalid", m1_bvalid, 1);
      chk("bhold_no_grant", {s_arvalid, m0_arready, s_bready}, 0);
      tick();
    end
    m1_bready = 1;
    push_exp(1'b1, 1'b1, 32'h0, 2'b10);
    #1;
    pop_check();
    tick();
    s_bvalid = 0;
    #1;
    chk("post_b_idle", s_arvalid, 0);
    tick();
    ar_phase(0, 32'h3000_0200, 3'd2);
    r_phase(0, 32'h5555_0000, 2'b00);

    // LSU read and write requested together: read first, then write.
    m1_arvalid = 1; m1_araddr = 32'h8000_0300; m1_arsize = 3'd1;
    m1_awvalid = 1; m1_awaddr = 32'h8000_0304; m1_wvalid = 1; m1_wdata = 32'h6666_7777; m1_wstrb = 4'hF;
    tick();
    chk("rw_aw_held", s_awvalid, 0);
    ar_phase(1, 32'h8000_0300, 3'd1);
    r_phase(1, 32'h7777_0000, 2'b00);
    tick();
    chk("rw_aw_valid", s_awvalid, 1);
    chk("rw_awid", s_awid, 4'd1);
    chk("rw_awaddr", s_awaddr, 32'h8000_0304);
    s_awready = 1; s_wready = 1;
    tick();
    s_awready = 0; s_wready = 0; m1_awvalid = 0; m1_wvalid = 0;
    push_exp(1'b1, 1'b1, 32'h0, 2'b00);
    s_bvalid = 1; s_bresp = 2'b00;
    #1;
    pop_check();
    tick();
    s_bvalid = 0;

    // Reset asserted while in R: everything drops at once, then a clean read.
    m0_arvalid = 1; m0_araddr = 32'h3000_0100;
    tick();
    ar_phase(0, 32'h3000_0100, 3'd2);
    s_rvalid = 1; s_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rstR_pre_rvalid", m0_rvalid, 1);
    rst_n = 0;
    #1;
    chk("rstR_drop", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_rvalid, m1_rvalid}, 0);
    s_rvalid = 0;
    tick();
    rst_n = 1;
    m0_arvalid = 1; m0_araddr = 32'h3000_0000;
    tick();
    ar_phase(0, 32'h3000_0000, 3'd2);
    r_phase(0, 32'hCAFE_F00D, 2'b00);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
